// File: rtl/matrix_win_gen.sv
// matrix_win_gen: turns a raster pixel stream into a WIN x WIN sliding window.
// WIN-1 line buffers supply the older rows. Full-width x/y coordinates travel
// alongside the data. The window valid is gated at the frame edges, and the
// first and last valid windows of each frame are flagged. sof_in re-anchors the
// counters, and the counters also wrap at the end of each frame.
module matrix_win_gen #(
    parameter int DATA_W = 24,
    parameter int IMG_W  = 1920,
    parameter int IMG_H  = 1080,
    parameter int WIN    = 2,
    localparam int CW    = $clog2(IMG_W),
    localparam int RW    = $clog2(IMG_H),
    localparam int WW    = WIN * WIN * DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_vld,
    input  logic [DATA_W-1:0] din,
    input  logic              sof_in,
    output logic              dout_vld,
    output logic [WW-1:0]     win_data,
    output logic [CW-1:0]     out_x,
    output logic [RW-1:0]     out_y,
    output logic              out_first,
    output logic              out_last
);

    logic              vld_p1_d, vld_p1_q, sof_p1_d, sof_p1_q;
    logic [DATA_W-1:0] pix_p1_d, pix_p1_q;
    logic [CW-1:0]     col_d, col_q, col_cur;
    logic [RW-1:0]     row_d, row_q, row_cur;
    logic              vld_p2_d, vld_p2_q;
    logic [CW-1:0]     col_p2_d, col_p2_q;
    logic [RW-1:0]     row_p2_d, row_p2_q;
    logic [DATA_W-1:0] pix_p2_d, pix_p2_q;
    logic              gate_p3_d, gate_p3_q;
    logic [CW-1:0]     col_p3_d, col_p3_q;
    logic [RW-1:0]     row_p3_d, row_p3_q;
    logic [WW-1:0]     win_d, win_q;
    logic              dout_vld_d, dout_vld_q, out_first_d, out_first_q, out_last_d, out_last_q;
    logic [CW-1:0]     out_x_d, out_x_q;
    logic [RW-1:0]     out_y_d, out_y_q;
    logic [WW-1:0]     win_data_d, win_data_q;
    logic [DATA_W-1:0] lb_rd [WIN-1];
    logic [DATA_W-1:0] lb_wr [WIN-1];
    logic [DATA_W-1:0] col_vec [WIN];

    // Stage 1 input capture and raster position of the stage-1 pixel
    always_comb begin
        vld_p1_d = din_vld;
        sof_p1_d = din_vld & sof_in;
        pix_p1_d = din;
        // sof anchors this pixel at (0,0) regardless of where the counters were
        col_cur  = sof_p1_q ? '0 : col_q;
        row_cur  = sof_p1_q ? '0 : row_q;
        col_d    = col_q;
        row_d    = row_q;
        if (vld_p1_q) begin
            if (col_cur == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_cur == RW'(IMG_H - 1)) ? '0 : row_cur + 1'b1;
            end else begin
                col_d = col_cur + 1'b1;
                row_d = row_cur;
            end
        end
    end

    // Stage 1 registers and position counters; pixel data is not reset
    always_ff @(posedge clk) begin
        pix_p1_q <= pix_p1_d;
        if (rst) begin
            vld_p1_q <= 1'b0;
            sof_p1_q <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            sof_p1_q <= sof_p1_d;
            col_q    <= col_d;
            row_q    <= row_d;
        end
    end

    // Line buffers: RAM k holds line y-1-k. Each RAM is read at stage 1 and
    // written at stage 2 with the line it just handed on, so the chain ages by one line.
    for (genvar k = 0; k < WIN - 1; k++) begin : g_lb
        logic [DATA_W-1:0] mem [IMG_W];
        logic [DATA_W-1:0] rd_q;
        if (k == 0) begin : g_head
            assign lb_wr[k] = pix_p2_q;
        end else begin : g_chain
            assign lb_wr[k] = lb_rd[k-1];
        end
        // Registered read at the stage-1 column; write back at the stage-2 column
        always_ff @(posedge clk) begin
            if (vld_p1_q) rd_q <= mem[col_cur];
            if (vld_p2_q) mem[col_p2_q] <= lb_wr[k];
        end
        assign lb_rd[k] = rd_q;
    end

    // Column vector for the window: r=0 oldest line, r=WIN-1 current pixel
    for (genvar r = 0; r < WIN; r++) begin : g_col
        if (r == WIN - 1) begin : g_cur
            assign col_vec[r] = pix_p2_q;
        end else begin : g_old
            assign col_vec[r] = lb_rd[WIN-2-r];
        end
    end

    // Stage 2 forwarding, window shift and edge gate
    always_comb begin
        vld_p2_d = vld_p1_q;
        col_p2_d = col_cur;
        row_p2_d = row_cur;
        pix_p2_d = pix_p1_q;
        win_d    = win_q;
        if (vld_p2_q) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    if (c < WIN - 1)
                        win_d[(r*WIN+c)*DATA_W +: DATA_W] = win_q[(r*WIN+c+1)*DATA_W +: DATA_W];
                    else
                        win_d[(r*WIN+c)*DATA_W +: DATA_W] = col_vec[r];
                end
            end
        end
        // Columns left over from the previous line or frame stay hidden until WIN fresh ones are in
        gate_p3_d = vld_p2_q && (col_p2_q >= CW'(WIN - 1)) && (row_p2_q >= RW'(WIN - 1));
        col_p3_d  = col_p2_q;
        row_p3_d  = row_p2_q;
    end

    // Stage 2 -> stage 3 registers; window contents are data and not reset
    always_ff @(posedge clk) begin
        pix_p2_q <= pix_p2_d;
        win_q    <= win_d;
        if (rst) begin
            vld_p2_q  <= 1'b0;
            col_p2_q  <= '0;
            row_p2_q  <= '0;
            gate_p3_q <= 1'b0;
            col_p3_q  <= '0;
            row_p3_q  <= '0;
        end else begin
            vld_p2_q  <= vld_p2_d;
            col_p2_q  <= col_p2_d;
            row_p2_q  <= row_p2_d;
            gate_p3_q <= gate_p3_d;
            col_p3_q  <= col_p3_d;
            row_p3_q  <= row_p3_d;
        end
    end

    // Output stage: coordinates and window update only on valid, otherwise hold
    always_comb begin
        dout_vld_d  = gate_p3_q;
        out_x_d     = gate_p3_q ? col_p3_q : out_x_q;
        out_y_d     = gate_p3_q ? row_p3_q : out_y_q;
        win_data_d  = gate_p3_q ? win_q : win_data_q;
        out_first_d = gate_p3_q && (col_p3_q == CW'(WIN - 1)) && (row_p3_q == RW'(WIN - 1));
        out_last_d  = gate_p3_q && (col_p3_q == CW'(IMG_W - 1)) && (row_p3_q == RW'(IMG_H - 1));
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_vld_q  <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            win_data_q  <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            dout_vld_q  <= dout_vld_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            win_data_q  <= win_data_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
        end
    end

    assign dout_vld  = dout_vld_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign win_data  = win_data_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_matrix_win_gen.sv
// Bench for matrix_win_gen: a WIN=2 8x4 instance and a WIN=3 8x5 instance,
// checked every cycle against a frame-image reference model.
module tb_matrix_win_gen;

    localparam int DW = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic vld0, sof0, vld1, sof1;
    logic [DW-1:0] din0, din1;
    logic dv0, f0, l0, dv1, f1, l1;
    logic [95:0]  wd0;
    logic [215:0] wd1;
    logic [2:0] ox0, ox1, oy1;
    logic [1:0] oy0;

    matrix_win_gen #(.DATA_W(DW), .IMG_W(8), .IMG_H(4), .WIN(2)) u_dut2 (
        .clk(clk), .rst(rst), .din_vld(vld0), .din(din0), .sof_in(sof0),
        .dout_vld(dv0), .win_data(wd0), .out_x(ox0), .out_y(oy0),
        .out_first(f0), .out_last(l0));

    matrix_win_gen #(.DATA_W(DW), .IMG_W(8), .IMG_H(5), .WIN(3)) u_dut3 (
        .clk(clk), .rst(rst), .din_vld(vld1), .din(din1), .sof_in(sof1),
        .dout_vld(dv1), .win_data(wd1), .out_x(ox1), .out_y(oy1),
        .out_first(f1), .out_last(l1));

    typedef struct {
        int due;
        int x;
        int y;
        bit first;
        bit last;
        logic [215:0] win;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int img [2][5][8];
    int px[2], py[2], hx[2], hy[2];
    int cyc = 0, total = 0, passes = 0, fails = 0;
    int nvalid[2], nfirst[2], nlast[2], lx[2], ly[2];
    logic [215:0] fw[2], lw[2];
    bit nv[2], ns[2], nrst;
    int np[2];

    function automatic int win_n(int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int img_h(int d);
        return (d == 0) ? 4 : 5;
    endfunction

    function automatic logic [215:0] pack4(int a, int b, int c, int d);
        return {120'b0, DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    task automatic chk(string tag, logic [215:0] obs, logic [215:0] expv);
        total++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: place each accepted pixel in a frame image, emit the window 3 clk later
    task automatic model_in(int d, int pix, bit sof);
        int n, h, x, y;
        exp_t e;
        n = win_n(d);
        h = img_h(d);
        if (sof) begin
            px[d] = 0;
            py[d] = 0;
        end
        x = px[d];
        y = py[d];
        img[d][y][x] = pix;
        if (x >= n - 1 && y >= n - 1) begin
            e.due   = cyc + 3;
            e.x     = x;
            e.y     = y;
            e.first = (x == n - 1 && y == n - 1);
            e.last  = (x == 7 && y == h - 1);
            e.win   = '0;
            for (int r = 0; r < n; r++)
                for (int c = 0; c < n; c++)
                    e.win[(r*n+c)*DW +: DW] = DW'(img[d][y-n+1+r][x-n+1+c]);
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        px[d]++;
        if (px[d] == 8) begin
            px[d] = 0;
            py[d]++;
            if (py[d] == h) py[d] = 0;
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            px[d] = 0; py[d] = 0; hx[d] = 0; hy[d] = 0;
        end
    endtask

    task automatic check(int d);
        exp_t e;
        bit exp_v;
        logic obs_v, obs_f, obs_l;
        logic [215:0] obs_w;
        logic [31:0] obs_x, obs_y;
        string tg;
        exp_v = 1'b0;
        if (d == 0) begin
            obs_v = dv0; obs_f = f0; obs_l = l0; obs_w = {120'b0, wd0};
            obs_x = {29'b0, ox0}; obs_y = {30'b0, oy0};
            if (q0.size() > 0 && q0[0].due == cyc) begin exp_v = 1'b1; e = q0.pop_front(); end
        end else begin
            obs_v = dv1; obs_f = f1; obs_l = l1; obs_w = wd1;
            obs_x = {29'b0, ox1}; obs_y = {29'b0, oy1};
            if (q1.size() > 0 && q1[0].due == cyc) begin exp_v = 1'b1; e = q1.pop_front(); end
        end
        tg = $sformatf("d%0d_c%0d", d, cyc);
        chk({tg, "_vld"}, obs_v, exp_v);
        if (obs_v === 1'b1) begin
            nvalid[d]++;
            if (obs_f === 1'b1) begin nfirst[d]++; fw[d] = obs_w; end
            if (obs_l === 1'b1) begin nlast[d]++; lw[d] = obs_w; lx[d] = obs_x; ly[d] = obs_y; end
        end
        if (exp_v) begin
            chk({tg, "_x"}, obs_x, e.x);
            chk({tg, "_y"}, obs_y, e.y);
            chk({tg, "_first"}, obs_f, e.first);
            chk({tg, "_last"}, obs_l, e.last);
            chk({tg, "_win"}, obs_w, e.win);
            hx[d] = e.x;
            hy[d] = e.y;
        end else begin
            chk({tg, "_xhold"}, obs_x, hx[d]);
            chk({tg, "_yhold"}, obs_y, hy[d]);
            chk({tg, "_first0"}, obs_f, 1'b0);
            chk({tg, "_last0"}, obs_l, 1'b0);
        end
    endtask

    task automatic step();
        rst  = nrst;
        vld0 = nv[0]; din0 = DW'(np[0]); sof0 = ns[0];
        vld1 = nv[1]; din1 = DW'(np[1]); sof1 = ns[1];
        @(posedge clk);
        cyc++;
        if (nrst) model_reset();
        else begin
            if (nv[0]) model_in(0, np[0], ns[0]);
            if (nv[1]) model_in(1, np[1], ns[1]);
        end
        @(negedge clk);
        check(0);
        check(1);
        nv[0] = 1'b0; nv[1] = 1'b0; ns[0] = 1'b0; ns[1] = 1'b0; nrst = 1'b0;
    endtask

    task automatic idle(int k);
        for (int i = 0; i < k; i++) step();
    endtask

    // gap: 0 continuous, 1 alternate valid/idle, 2 random idle cycles
    task automatic feed_frame(int d, int base, bit rnd, int gap, bit sof_first, int npix);
        for (int i = 0; i < npix; i++) begin
            if (gap == 2 && $urandom_range(0, 2) == 0) step();
            nv[d] = 1'b1;
            np[d] = rnd ? int'($urandom_range(0, 32'h00FF_FFFF)) : base + (i / 8) * 16 + (i % 8);
            ns[d] = sof_first && (i == 0);
            step();
            if (gap == 1) step();
        end
    endtask

    int c0, c1, nf0, nl0;

    initial begin
        nv[0] = 0; nv[1] = 0; ns[0] = 0; ns[1] = 0; np[0] = 0; np[1] = 0;
        for (int d = 0; d < 2; d++) begin
            nvalid[d] = 0; nfirst[d] = 0; nlast[d] = 0; lx[d] = 0; ly[d] = 0;
            fw[d] = '0; lw[d] = '0;
        end
        model_reset();
        rst = 1'b1; vld0 = 0; vld1 = 0; sof0 = 0; sof1 = 0; din0 = '0; din1 = '0;
        nrst = 1'b1;
        step();
        nrst = 1'b1;
        step();
        chk("rst_win0", {120'b0, wd0}, '0);
        chk("rst_win1", wd1, '0);

        // Continuous ramp, WIN=2
        c0 = nvalid[0];
        feed_frame(0, 0, 1'b0, 0, 1'b1, 32);
        idle(4);
        chk("s1_count", nvalid[0] - c0, 21);
        chk("s1_first_win", fw[0], pack4(0, 1, 16, 17));
        chk("s1_last_win", lw[0], pack4(38, 39, 54, 55));
        chk("s1_last_x", lx[0], 7);
        chk("s1_last_y", ly[0], 3);

        // Alternating valid, same frame
        c0 = nvalid[0];
        lw[0] = '0;
        feed_frame(0, 0, 1'b0, 1, 1'b1, 32);
        idle(4);
        chk("s2_count", nvalid[0] - c0, 21);
        chk("s2_first_win", fw[0], pack4(0, 1, 16, 17));
        chk("s2_last_win", lw[0], pack4(38, 39, 54, 55));

        // WIN=3 ramp
        c1 = nvalid[1];
        feed_frame(1, 0, 1'b0, 0, 1'b1, 40);
        idle(4);
        chk("s3_count", nvalid[1] - c1, 18);
        chk("s3_centre", fw[1][119:96], 17);
        chk("s3_corner", fw[1][215:192], 34);
        chk("s3_last_x", lx[1], 7);
        chk("s3_last_y", ly[1], 4);

        // Mid-frame sof at old pixel (4,2); new frame offset by 128
        c0 = nvalid[0];
        fw[0] = '0;
        feed_frame(0, 0, 1'b0, 0, 1'b1, 20);
        feed_frame(0, 128, 1'b0, 0, 1'b1, 32);
        idle(4);
        chk("s4_count", nvalid[0] - c0, 31);
        chk("s4_first_win", fw[0], pack4(128, 129, 144, 145));

        // Reset during row 2, then restart without sof
        feed_frame(0, 0, 1'b0, 0, 1'b1, 20);
        nrst = 1'b1;
        step();
        chk("s5_rst_vld", dv0, 1'b0);
        chk("s5_rst_win", {120'b0, wd0}, '0);
        chk("s5_rst_x", ox0, 0);
        chk("s5_rst_y", oy0, 0);
        c0 = nvalid[0];
        fw[0] = '0;
        lw[0] = '0;
        feed_frame(0, 0, 1'b0, 0, 1'b0, 32);
        idle(4);
        chk("s5_count", nvalid[0] - c0, 21);
        chk("s5_first_win", fw[0], pack4(0, 1, 16, 17));
        chk("s5_last_win", lw[0], pack4(38, 39, 54, 55));

        // Two random frames back to back, no gap and no sof on the second
        c0 = nvalid[0]; nf0 = nfirst[0]; nl0 = nlast[0];
        feed_frame(0, 0, 1'b1, 0, 1'b1, 32);
        feed_frame(0, 0, 1'b1, 0, 1'b0, 32);
        idle(4);
        chk("s6_count", nvalid[0] - c0, 42);
        chk("s6_firsts", nfirst[0] - nf0, 2);
        chk("s6_lasts", nlast[0] - nl0, 2);

        // Random pixels and random gaps on both instances together
        c0 = nvalid[0];
        c1 = nvalid[1];
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            if (i < 64) begin
                nv[0] = 1'b1;
                np[0] = int'($urandom_range(0, 32'h00FF_FFFF));
                ns[0] = (i == 0);
            end
            nv[1] = 1'b1;
            np[1] = int'($urandom_range(0, 32'h00FF_FFFF));
            ns[1] = (i == 0);
            step();
        end
        idle(4);
        chk("s7_count0", nvalid[0] - c0, 42);
        chk("s7_count1", nvalid[1] - c1, 36);
        chk("drain0", q0.size(), 0);
        chk("drain1", q1.size(), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
